// File: rtl/cpu_dma_tx_pkg.sv
// Shared definitions for the CPU DMA TX reader: widths, limits, FSM states,
// output-buffer entry layout and the last-word ctrl-to-byte-count mapping.
package cpu_dma_tx_pkg;

    localparam int unsigned DMA_DATA_WIDTH = 32;
    localparam int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8;
    localparam int unsigned MAX_PKT_BYTES  = 2048;
    localparam int unsigned LEN_WIDTH      = 12;
    localparam int unsigned BUF_CNT_WIDTH  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_REQ   = 3'd2,
        ST_BODY  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    typedef struct packed {
        logic                      last;
        logic [DMA_DATA_WIDTH-1:0] data;
    } buf_entry_t;

    // Highest set ctrl bit k means k+1 valid bytes in the last word.
    function automatic logic [LEN_WIDTH-1:0] ctrl_bytes(input logic [DMA_CTRL_WIDTH-1:0] ctrl);
        logic [LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DMA_CTRL_WIDTH); i++) begin
            if (ctrl[i]) n = LEN_WIDTH'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/cpu_dma_tx_out_buf.sv
// Two-entry valid/ready buffer of {last, data} words.
// Ports: clk, reset (sync, active high); push/push_entry write side (caller
// guarantees cnt < 2 when pushing); pop_rdy read-side ready; vld/head expose
// the oldest entry; cnt is the registered occupancy.
module cpu_dma_tx_out_buf
    import cpu_dma_tx_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  buf_entry_t               push_entry,
    input  logic                     pop_rdy,
    output logic                     vld,
    output buf_entry_t               head,
    output logic [BUF_CNT_WIDTH-1:0] cnt
);

    buf_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_pop;

    assign vld    = (cnt != '0);
    assign head   = mem[rd_ptr];
    assign do_pop = vld && pop_rdy;

    // Storage and pointers; entries are cleared on reset so data reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + BUF_CNT_WIDTH'(push) - BUF_CNT_WIDTH'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_dma_tx_reader.sv
// Pops packets (header word with byte length, then body words) from the CPU
// DMA TX queue, requests a host transfer of that length and streams the body
// through a 2-entry buffer, checking the counted length against the header.
// Ports: clk, reset (sync, active high), rd_en; queue side cpu_q_dma_*;
// engine side dma_req/dma_len/dma_grant and dma_data/dma_vld/dma_last/dma_rdy;
// status pulses pkt_done and len_err.
module cpu_dma_tx_reader
    import cpu_dma_tx_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_en,
    input  logic                      cpu_q_dma_pkt_avail,
    input  logic                      cpu_q_dma_rd_rdy,
    output logic                      cpu_q_dma_rd,
    input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
    input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
    output logic                      dma_req,
    output logic [LEN_WIDTH-1:0]      dma_len,
    input  logic                      dma_grant,
    output logic [DMA_DATA_WIDTH-1:0] dma_data,
    output logic                      dma_vld,
    output logic                      dma_last,
    input  logic                      dma_rdy,
    output logic                      pkt_done,
    output logic                      len_err
);

    state_t                   state, state_nxt;
    logic [LEN_WIDTH-1:0]     len_reg;
    logic [LEN_WIDTH-1:0]     byte_cnt;
    logic                     hdr_bad;
    logic                     sat_seen;
    logic                     rd;
    logic                     dma_req_nxt, pkt_done_nxt, len_err_nxt;
    logic [BUF_CNT_WIDTH-1:0] buf_cnt;
    logic                     buf_vld;
    buf_entry_t               head;
    logic                     rd_last;
    logic [LEN_WIDTH-1:0]     cap_len;
    logic                     cap_bad;
    logic [LEN_WIDTH:0]       sum;
    logic [LEN_WIDTH-1:0]     word_cnt;

    assign rd_last  = (cpu_q_dma_rd_ctrl != '0);
    assign cap_len  = cpu_q_dma_rd_data[LEN_WIDTH-1:0];
    assign cap_bad  = (cap_len == '0) || (cap_len > LEN_WIDTH'(MAX_PKT_BYTES));
    assign sum      = {1'b0, byte_cnt}
                    + {1'b0, (rd_last ? ctrl_bytes(cpu_q_dma_rd_ctrl) : LEN_WIDTH'(4))};
    // Saturating byte count including the word being read now.
    assign word_cnt = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rd_en && cpu_q_dma_pkt_avail) state_nxt = ST_HDR;
            ST_HDR:   if (cpu_q_dma_rd_rdy)             state_nxt = ST_REQ;
            ST_REQ:   if (dma_grant)                    state_nxt = ST_BODY;
            ST_BODY:  if (rd && rd_last)                state_nxt = ST_FLUSH;
            ST_FLUSH: if (buf_cnt == '0)                state_nxt = ST_IDLE;
            default:                                    state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: the pop strobe is combinational from rd_rdy and registered
    // occupancy only; the rest are next values of registered outputs.
    always_comb begin
        rd           = 1'b0;
        dma_req_nxt  = 1'b0;
        len_err_nxt  = 1'b0;
        pkt_done_nxt = buf_vld && dma_rdy && head.last;
        case (state)
            ST_HDR: begin
                rd          = cpu_q_dma_rd_rdy;
                dma_req_nxt = cpu_q_dma_rd_rdy;
                len_err_nxt = cpu_q_dma_rd_rdy && cap_bad;
            end
            ST_REQ: dma_req_nxt = !dma_grant;
            ST_BODY: begin
                rd          = cpu_q_dma_rd_rdy && (buf_cnt != BUF_CNT_WIDTH'(2));
                // A bad header already reported this packet's single len_err.
                len_err_nxt = rd && rd_last && !hdr_bad
                            && (sat_seen || sum[LEN_WIDTH] || (word_cnt != len_reg));
            end
            default: ;
        endcase
    end

    // Length/counter datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg  <= '0;
            byte_cnt <= '0;
            hdr_bad  <= 1'b0;
            sat_seen <= 1'b0;
            dma_req  <= 1'b0;
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            dma_req  <= dma_req_nxt;
            pkt_done <= pkt_done_nxt;
            len_err  <= len_err_nxt;
            if (state == ST_HDR && rd) begin
                len_reg  <= cap_len;
                byte_cnt <= '0;
                hdr_bad  <= cap_bad;
                sat_seen <= 1'b0;
            end else if (state == ST_BODY && rd) begin
                byte_cnt <= word_cnt;
                sat_seen <= sat_seen || sum[LEN_WIDTH];
            end
        end
    end

    assign cpu_q_dma_rd = rd;
    assign dma_len      = len_reg;
    assign dma_vld      = buf_vld;
    assign dma_data     = head.data;
    assign dma_last     = head.last;

    cpu_dma_tx_out_buf u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (state == ST_BODY && rd),
        .push_entry ('{last: rd_last, data: cpu_q_dma_rd_data}),
        .pop_rdy    (dma_rdy),
        .vld        (buf_vld),
        .head       (head),
        .cnt        (buf_cnt)
    );

endmodule

// File: doc/cpu_dma_tx_reader.md
Name: cpu_dma_tx_reader

Overview:
Sits directly downstream of the CPU DMA TX queue and upstream of the CPCI DMA transfer engine. It pops one packet at a time from the queue's DMA read interface: first the header word carrying the byte length, then the 32-bit little-endian body words. It requests a host transfer with that length and streams the body words through a 2-entry output buffer under valid/ready. It checks the counted byte length against the header and reports per-packet status pulses.

Parameters:
DMA_DATA_WIDTH, 32, queue/DMA data word width; only 32 is supported.
DMA_CTRL_WIDTH, DMA_DATA_WIDTH/8, queue ctrl width.
MAX_PKT_BYTES, 2048, largest legal packet length in bytes.
LEN_WIDTH, 12, width of the byte-length field and of the byte counter.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high reset.
rd_en  in  1  when low, no new packet is started; a packet already in progress completes.
cpu_q_dma_pkt_avail  in  1  at least one complete packet is queued.
cpu_q_dma_rd_rdy  in  1  queue read data is valid.
cpu_q_dma_rd  out  1  pop strobe; data is consumed in the same cycle.
cpu_q_dma_rd_data  in  DMA_DATA_WIDTH  header or body word.
cpu_q_dma_rd_ctrl  in  DMA_CTRL_WIDTH  0 = non-last word; nonzero = last word.
dma_req  out  1  request a host transfer.
dma_len  out  LEN_WIDTH  byte length; valid while dma_req is high.
dma_grant  in  1  engine accepts the request.
dma_data  out  DMA_DATA_WIDTH  body word.
dma_vld  out  1  dma_data is valid.
dma_last  out  1  dma_data is the packet's last word.
dma_rdy  in  1  engine accepts the word when dma_vld && dma_rdy.
pkt_done  out  1  one-cycle pulse when the last word is accepted.
len_err  out  1  one-cycle pulse on a length violation.

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE, the buffer is emptied and the counters are cleared. Reset mid-packet abandons the packet; the queue is reset by the same signal.
- cpu_q_dma_rd never asserts unless cpu_q_dma_rd_rdy is high. It has no combinational path from dma_rdy or dma_grant.
- FSM states: IDLE, HDR, REQ, BODY, FLUSH.
- IDLE: if rd_en && cpu_q_dma_pkt_avail, go to HDR next cycle.
- HDR: when cpu_q_dma_rd_rdy, assert cpu_q_dma_rd for exactly 1 cycle and capture rd_data[LEN_WIDTH-1:0] into len_reg, then go to REQ.
  - If the captured length is 0 or greater than MAX_PKT_BYTES, pulse len_err; the packet is still transferred and drained.
- REQ: dma_req = 1 and dma_len = len_reg, both registered. On dma_grant, deassert dma_req the next cycle and go to BODY.
- BODY:
  - Read condition: cpu_q_dma_rd = cpu_q_dma_rd_rdy && buf_cnt < 2. buf_cnt is registered; a pop and a push in the same cycle are allowed.
  - Each word read is pushed into the buffer together with last = (rd_ctrl != 0).
  - Byte counter: add 4 for a non-last word. For the last word, add k+1, where k is the highest set bit of rd_ctrl.
  - On reading the last word, go to FLUSH.
- FLUSH: wait until the buffer is empty (last word accepted), then go to IDLE. pkt_done pulses in the cycle after the last word is accepted.
- Length check at the last word: if the accumulated byte count != len_reg, pulse len_err once, 1 cycle after the last word is read. At most one len_err per packet.
- Output buffer: 2-entry FIFO.
  - dma_vld = !empty; dma_data and dma_last come from the head entry.
  - A pop happens when dma_vld && dma_rdy.
  - It never overflows (reads are gated) and never underflows.
- Byte counter width is LEN_WIDTH. A count that would exceed 4095 saturates at 4095 and is reported as len_err.
- rd_en falling mid-packet has no effect until the FSM returns to IDLE.
- Throughput: with dma_rdy and rd_rdy held high, 1 word per cycle in BODY. Overhead is 1 HDR cycle, REQ wait, and 1 FLUSH cycle.

Decomposition:
- Shared package (or include file): FSM state encodings, MAX_PKT_BYTES, LEN_WIDTH, and the ctrl-to-byte-count mapping function (highest set bit k gives k+1 bytes).
- One sub-module: cpu_dma_tx_out_buf, a 2-entry valid/ready buffer of {last, data} that exposes its occupancy count.

Test Plan:
- 64-byte packet, header 0x040, 16 words, last ctrl 0x8, dma_rdy always 1 → dma_req with dma_len 0x040; 16 dma_vld beats, dma_last on beat 16; pkt_done once; no len_err.
- 61-byte packet, header 0x03D, last ctrl 0x1 → 16 beats; count 60+1 = 61; pkt_done; no len_err.
- Header 0x040 but only 15 body words delivered, last ctrl 0x8 → len_err pulse 1 cycle after the last read; pkt_done still asserted.
- dma_rdy toggling 1010…, rd_rdy random → no word lost or duplicated; cpu_q_dma_rd never high while buf_cnt = 2 or rd_rdy is low.
- dma_grant delayed 20 cycles → dma_req and dma_len held stable; no body reads before grant. Two back-to-back packets → second HDR read starts after the first pkt_done.
- reset asserted mid-BODY → next cycle all outputs are 0 and state is IDLE; after reset, a fresh packet transfers correctly. rd_en = 0 with pkt_avail = 1 → no reads.
